// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, phase encodings and phase-advance helper.
// Latency: n/a (package). Backpressure: n/a (free-running video timing).
// Contents: default 640x480@60 timing, H/V totals, counter width, phase_t, phase_step().
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // Next phase given the value the axis counter is about to take.
    function automatic phase_t phase_step(
        input phase_t           cur,
        input logic [CNT_W-1:0] nxt,
        input logic [CNT_W-1:0] fp_start,
        input logic [CNT_W-1:0] sync_start,
        input logic [CNT_W-1:0] bp_start
    );
        phase_t r;
        r = cur;
        case (cur)
            PH_ACTIVE: if (nxt == fp_start)   r = PH_FRONT;
            PH_FRONT:  if (nxt == sync_start) r = PH_SYNC;
            PH_SYNC:   if (nxt == bp_start)   r = PH_BACK;
            PH_BACK:   if (nxt == '0)         r = PH_ACTIVE;
            default:                          r = PH_ACTIVE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_tick.sv
// Pixel-rate divider: strobe every CLK_DIV clocks plus a registered copy for output.
// Latency: o_tick_en combinational from r_cnt; o_pixel_tick one clock after o_tick_en.
// Backpressure: none, free-running.
// Ports: clock, reset (async active-high), o_tick_en (internal advance strobe),
//        o_pixel_tick (registered pulse, aligned with the timing outputs).
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    output logic o_tick_en,
    output logic o_pixel_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] r_cnt;

    // With CLK_DIV=1 r_cnt stays at 0 and the strobe is permanently high.
    assign o_tick_en = (r_cnt == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            o_pixel_tick <= 1'b0;
        end else begin
            r_cnt        <= o_tick_en ? 4'd0 : r_cnt + 4'd1;
            o_pixel_tick <= o_tick_en;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: h/v counters with per-axis phase FSMs, registered pixel/sync outputs.
// Latency: outputs describe the counter position sampled on the same edge that asserts pixel_tick.
// Backpressure: none, free-running; outputs hold between pixel ticks.
// Ports: clock, reset (async active-high); pixel_tick, pixel_x, pixel_y, video_active,
//        h_sync (pin), v_sync (logical), v_sync_pin (pin), frame_start.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_active,
    output logic             h_sync,
    output logic             v_sync,
    output logic             v_sync_pin,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FP_START   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BP_START   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FP_START   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BP_START   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
            $error("vga_timing: H_TOTAL or V_TOTAL does not fit the 10-bit counters");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing: CLK_DIV must be within 1..16");
        end
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase
            $error("vga_timing: every timing phase must be at least one unit long");
        end
    endgenerate

    logic             w_tick_en;
    logic             w_h_wrap;
    logic [CNT_W-1:0] w_h_count_nxt;
    logic [CNT_W-1:0] w_v_count_nxt;
    phase_t           w_h_phase_nxt;
    phase_t           w_v_phase_nxt;
    logic             w_active;

    logic [CNT_W-1:0] r_h_count;
    logic [CNT_W-1:0] r_v_count;
    phase_t           r_h_phase;
    phase_t           r_v_phase;

    logic [CNT_W-1:0] r_pixel_x;
    logic [CNT_W-1:0] r_pixel_y;
    logic             r_video_active;
    logic             r_h_sync_pin;
    logic             r_v_sync;
    logic             r_v_sync_pin;
    logic             r_frame_start;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock        (clock),
        .reset        (reset),
        .o_tick_en    (w_tick_en),
        .o_pixel_tick (pixel_tick)
    );

    // Next-state: counters and phases move together so the phase always
    // matches the counter value it sits beside.
    always_comb begin
        w_h_wrap      = (r_h_count == H_LAST);
        w_h_count_nxt = r_h_count;
        w_v_count_nxt = r_v_count;
        w_h_phase_nxt = r_h_phase;
        w_v_phase_nxt = r_v_phase;
        if (w_tick_en) begin
            w_h_count_nxt = w_h_wrap ? '0 : r_h_count + 10'd1;
            w_h_phase_nxt = phase_step(r_h_phase, w_h_count_nxt,
                                       H_FP_START, H_SYNC_START, H_BP_START);
            if (w_h_wrap) begin
                w_v_count_nxt = (r_v_count == V_LAST) ? '0 : r_v_count + 10'd1;
                w_v_phase_nxt = phase_step(r_v_phase, w_v_count_nxt,
                                           V_FP_START, V_SYNC_START, V_BP_START);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_h_phase <= PH_ACTIVE;
            r_v_phase <= PH_ACTIVE;
        end else begin
            r_h_count <= w_h_count_nxt;
            r_v_count <= w_v_count_nxt;
            r_h_phase <= w_h_phase_nxt;
            r_v_phase <= w_v_phase_nxt;
        end
    end

    assign w_active = (r_h_phase == PH_ACTIVE) && (r_v_phase == PH_ACTIVE);

    // All visible outputs load from the pre-advance state on the tick edge,
    // so they line up with the registered pixel_tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pixel_x      <= '0;
            r_pixel_y      <= '0;
            r_video_active <= 1'b0;
            r_h_sync_pin   <= SYNC_NEG;
            r_v_sync       <= 1'b0;
            r_v_sync_pin   <= SYNC_NEG;
            r_frame_start  <= 1'b0;
        end else begin
            r_frame_start <= w_tick_en && (r_h_count == '0) && (r_v_count == '0);
            if (w_tick_en) begin
                r_pixel_x      <= w_active ? r_h_count : '0;
                r_pixel_y      <= w_active ? r_v_count : '0;
                r_video_active <= w_active;
                r_h_sync_pin   <= (r_h_phase == PH_SYNC) ^ SYNC_NEG;
                r_v_sync       <= (r_v_phase == PH_SYNC);
                r_v_sync_pin   <= (r_v_phase == PH_SYNC) ^ SYNC_NEG;
            end
        end
    end

    assign pixel_x      = r_pixel_x;
    assign pixel_y      = r_pixel_y;
    assign video_active = r_video_active;
    assign h_sync       = r_h_sync_pin;
    assign v_sync       = r_v_sync;
    assign v_sync_pin   = r_v_sync_pin;
    assign frame_start  = r_frame_start;

endmodule
